fp_align_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational floating-point alignment stage.
- Accepts two raw operands, orders them by magnitude, and right-shifts the smaller significand to the larger exponent.
- Preserves guard/round/sticky bits instead of truncating, and handles subnormals.
- Sits between operand fetch and the significand adder of the FP add/sub datapath, with valid/ready handshakes on both sides.

---
 rtl/fp_align_pipe.sv | 142 ++++++++++++++
 tb/tb_fp_align_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_pipe.sv
// rtl/fp_align_pipe.sv - two-stage elastic FP operand alignment (order, swap, shift with GRS)
//
// Purpose: orders two packed FP operands by magnitude and right-aligns the
// smaller significand to the larger exponent, keeping guard/round/sticky.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready, a, b   operand pair handshake, packed {sign,exp,frac}
//   out_valid/out_ready       result handshake
//   big_sign/big_exp/big_sig  larger operand (effective exponent, hidden bit included)
//   small_sign/small_sig      smaller operand, significand shifted by exp_diff
//   guard/round_b/sticky      bits shifted out of small_sig
//   swapped                   1 when B was the larger operand
//   exp_diff                  big_exp minus small effective exponent
module fp_align_pipe #(
  parameter int EXP_BITS  = 8,
  parameter int FRAC_BITS = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [EXP_BITS+FRAC_BITS:0]   a,
  input  logic [EXP_BITS+FRAC_BITS:0]   b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          big_sign,
  output logic [EXP_BITS-1:0]           big_exp,
  output logic [FRAC_BITS:0]            big_sig,
  output logic                          small_sign,
  output logic [FRAC_BITS:0]            small_sig,
  output logic                          guard,
  output logic                          round_b,
  output logic                          sticky,
  output logic                          swapped,
  output logic [EXP_BITS-1:0]           exp_diff
);

  localparam int SIG = FRAC_BITS + 1;
  localparam int W   = 1 + EXP_BITS + FRAC_BITS;
  // Shift window: significand on top, SIG+2 zero bits below so that every
  // bit pushed out by a shift of up to SIG+2 remains visible for GRS.
  localparam int EXT = 2 * SIG + 2;

  // ---------------- operand unpack (combinational) ----------------
  logic                a_sign, b_sign;
  logic [EXP_BITS-1:0] a_exp, b_exp, a_eexp, b_eexp;
  logic [SIG-1:0]      a_sig, b_sig;
  logic                b_gt_a;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1];
  assign a_exp  = a[W-2 -: EXP_BITS];
  assign b_exp  = b[W-2 -: EXP_BITS];

  // Subnormals and zero use effective exponent 1 with a clear hidden bit.
  assign a_eexp = (|a_exp) ? a_exp : EXP_BITS'(1);
  assign b_eexp = (|b_exp) ? b_exp : EXP_BITS'(1);
  assign a_sig  = {|a_exp, a[FRAC_BITS-1:0]};
  assign b_sig  = {|b_exp, b[FRAC_BITS-1:0]};

  // Including the hidden bit makes a subnormal rank below a normal that
  // shares effective exponent 1. Ties keep A as the larger operand.
  assign b_gt_a = {b_eexp, b_sig} > {a_eexp, a_sig};

  // ---------------- pipeline control ----------------
  logic s1_valid;
  logic s2_ready;
  logic s1_adv;

  assign s2_ready = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s1_adv;

  // ---------------- stage 1 registers ----------------
  logic                s1_big_sign, s1_small_sign, s1_swapped;
  logic [EXP_BITS-1:0] s1_big_exp, s1_exp_diff;
  logic [SIG-1:0]      s1_big_sig, s1_small_sig;

  // ---------------- stage 2 shifter (combinational) ----------------
  logic           sat;
  logic [31:0]    sh_amt;
  logic [EXT-1:0] ext, shifted;

  assign sat     = 32'(s1_exp_diff) >= 32'(SIG + 2);
  assign sh_amt  = sat ? 32'(SIG + 2) : 32'(s1_exp_diff);
  assign ext     = {s1_small_sig, {(SIG + 2){1'b0}}};
  assign shifted = ext >> sh_amt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_big_sign   <= 1'b0;
      s1_big_exp    <= '0;
      s1_big_sig    <= '0;
      s1_small_sign <= 1'b0;
      s1_small_sig  <= '0;
      s1_swapped    <= 1'b0;
      s1_exp_diff   <= '0;
      out_valid     <= 1'b0;
      big_sign      <= 1'b0;
      big_exp       <= '0;
      big_sig       <= '0;
      small_sign    <= 1'b0;
      small_sig     <= '0;
      guard         <= 1'b0;
      round_b       <= 1'b0;
      sticky        <= 1'b0;
      swapped       <= 1'b0;
      exp_diff      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_swapped    <= b_gt_a;
        s1_big_sign   <= b_gt_a ? b_sign : a_sign;
        s1_big_exp    <= b_gt_a ? b_eexp : a_eexp;
        s1_big_sig    <= b_gt_a ? b_sig  : a_sig;
        s1_small_sign <= b_gt_a ? a_sign : b_sign;
        s1_small_sig  <= b_gt_a ? a_sig  : b_sig;
        s1_exp_diff   <= b_gt_a ? (b_eexp - a_eexp) : (a_eexp - b_eexp);
      end

      if (s2_ready) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        big_sign   <= s1_big_sign;
        big_exp    <= s1_big_exp;
        big_sig    <= s1_big_sig;
        small_sign <= s1_small_sign;
        small_sig  <= shifted[EXT-1 -: SIG];
        guard      <= shifted[SIG+1];
        round_b    <= shifted[SIG];
        sticky     <= |shifted[SIG-1:0];
        swapped    <= s1_swapped;
        exp_diff   <= s1_exp_diff;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_pipe.sv
// tb/tb_fp_align_pipe.sv - self-checking bench for fp_align_pipe
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        big_sign, small_sign, guard, round_b, sticky, swapped;
  logic [7:0]  big_exp, exp_diff;
  logic [23:0] big_sig, small_sig;

  fp_align_pipe #(.EXP_BITS(8), .FRAC_BITS(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .big_exp(big_exp), .big_sig(big_sig),
    .small_sign(small_sign), .small_sig(small_sig),
    .guard(guard), .round_b(round_b), .sticky(sticky),
    .swapped(swapped), .exp_diff(exp_diff)
  );

  always #5 clk = ~clk;

  typedef logic [69:0] res_t;
  res_t got;
  assign got = {big_sign, big_exp, big_sig, small_sign, small_sig,
                guard, round_b, sticky, swapped, exp_diff};

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: magnitude order of IEEE-style operands equals unsigned order of
  // the packed {exp,frac} field; alignment is plain integer shifting.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y);
    logic              sw;
    logic [31:0]       bg, sm;
    int                be, se, d;
    longint unsigned   bs, ss, sml, g, r, s;
    sw = (y[30:0] > x[30:0]);
    bg = sw ? y : x;
    sm = sw ? x : y;
    be = (bg[30:23] == 0) ? 1 : int'(bg[30:23]);
    se = (sm[30:23] == 0) ? 1 : int'(sm[30:23]);
    bs = ((bg[30:23] != 0) ? 64'h800000 : 64'h0) + 64'(bg[22:0]);
    ss = ((sm[30:23] != 0) ? 64'h800000 : 64'h0) + 64'(sm[22:0]);
    d  = be - se;
    sml = (d >= 64) ? 0 : (ss >> d);
    g   = (d >= 1 && d <= 64) ? ((ss >> (d - 1)) & 1) : 0;
    r   = (d >= 2 && d <= 65) ? ((ss >> (d - 2)) & 1) : 0;
    if (d < 3)            s = 0;
    else if (d - 2 >= 32) s = (ss != 0) ? 1 : 0;
    else                  s = ((ss & ((64'd1 << (d - 2)) - 1)) != 0) ? 1 : 0;
    return {bg[31], 8'(be), 24'(bs), sm[31], 24'(sml), g[0], r[0], s[0], sw, 8'(d)};
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  res_t q[$];
  res_t held;
  bit   hold_pending = 0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", got, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", out_valid, 0);
        else check("result", got, q.pop_front());
      end
      hold_pending = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) q.push_back(model(a, b));
    end
  end

  // One isolated pair with out_ready high; checks 2-cycle latency.
  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y);
    a = x; b = y; in_valid = 1;
    @(negedge clk) check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk) #1 in_valid = 0;
    @(negedge clk) check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk) check({tag, "_lat2"}, out_valid, 1);
    @(posedge clk) #1;
  endtask

  function automatic logic [31:0] rand_op(input logic [7:0] e);
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] p [4];
    logic [7:0]  ea, eb;
    int          t;

    rst = 1; in_valid = 0; out_ready = 1; a = 0; b = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", got, 0);
    @(posedge clk); @(posedge clk) #1 rst = 0;
    check("post_rst_in_ready", in_ready, 1);

    directed("basic", {1'b0, 8'h85, 23'h123456}, {1'b0, 8'h80, 23'h654321});
    check("basic_swapped", swapped, 0);
    check("basic_diff", exp_diff, 5);
    check("basic_big_sig", big_sig, 24'h923456);
    check("basic_small_sig", small_sig, 24'h072A19);
    check("basic_grs", {guard, round_b, sticky}, 3'b001);

    directed("swap", {1'b0, 8'h80, 23'h111111}, {1'b1, 8'h80, 23'h333333});
    check("swap_swapped", swapped, 1);
    check("swap_big_sign", big_sign, 1);
    check("swap_diff", exp_diff, 0);
    check("swap_small_sig", small_sig, 24'h911111);
    check("swap_grs", {guard, round_b, sticky}, 3'b000);

    directed("tie", {1'b1, 8'h7F, 23'h2AAAAA}, {1'b1, 8'h7F, 23'h2AAAAA});
    check("tie_swapped", swapped, 0);
    directed("zero_tie", 32'h8000_0000, 32'h0000_0000);
    check("zero_tie_swapped", swapped, 0);
    check("zero_tie_big_sign", big_sign, 1);

    directed("large", {1'b0, 8'h90, 23'h100000}, {1'b0, 8'h70, 23'h100000});
    check("large_diff", exp_diff, 8'h20);
    check("large_small_sig", small_sig, 0);
    check("large_grs", {guard, round_b, sticky}, 3'b001);

    directed("diff25", {1'b0, 8'h99, 23'h0}, {1'b0, 8'h80, 23'h000001});
    check("diff25_small_sig", small_sig, 0);
    check("diff25_grs", {guard, round_b, sticky}, 3'b011);

    directed("subn", {1'b0, 8'h01, 23'h0}, {1'b0, 8'h00, 23'h000004});
    check("subn_swapped", swapped, 0);
    check("subn_big_exp", big_exp, 1);
    check("subn_diff", exp_diff, 0);
    check("subn_big_sig", big_sig, 24'h800000);
    check("subn_small_sig", small_sig, 24'h000004);

    // Backpressure: four pairs against a stalled consumer.
    for (int i = 0; i < 4; i++) p[i] = $urandom;
    out_ready = 0; a = p[0]; b = ~p[0]; in_valid = 1;
    @(posedge clk) #1 a = p[1]; b = ~p[1];
    @(posedge clk) #1 a = p[2]; b = ~p[2];
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    repeat (3) @(negedge clk) check("bp_in_ready_hold", in_ready, 0);
    @(posedge clk) #1 out_ready = 1;
    @(negedge clk);
    check("bp_rel_ov0", out_valid, 1);
    check("bp_rel_in_ready", in_ready, 1);
    @(posedge clk) #1 a = p[3]; b = ~p[3];
    @(negedge clk) check("bp_rel_ov1", out_valid, 1);
    @(posedge clk) #1 in_valid = 0;
    @(negedge clk) check("bp_rel_ov2", out_valid, 1);
    @(negedge clk) check("bp_rel_ov3", out_valid, 1);
    @(negedge clk) check("bp_rel_ov4", out_valid, 0);
    check("bp_queue_empty", q.size(), 0);

    // Randomized traffic with random stalls on both sides.
    for (int i = 0; i < 400; i++) begin
      @(posedge clk) #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ea = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ea = 0;
      eb = ($urandom_range(0, 1) == 1) ? 8'(32'(ea) + $urandom_range(0, 30) - 15)
                                        : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) eb = 0;
      a = rand_op(ea);
      b = rand_op(eb);
    end
    @(posedge clk) #1 in_valid = 0; out_ready = 1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rand_drain", q.size(), 0);

    // Reset with two pairs in flight.
    @(posedge clk) #1 a = p[0]; b = p[1]; in_valid = 1;
    @(posedge clk) #1 a = p[2]; b = p[3];
    @(posedge clk) #1 in_valid = 0;
    check("mid_pre_rst_ov", out_valid, 1);
    #2 rst = 1;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_data", got, 0);
    @(posedge clk); @(posedge clk) #1 rst = 0;
    check("mid_post_in_ready", in_ready, 1);
    repeat (4) @(negedge clk) check("mid_no_stale", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
